// File: rtl/gpu_instruction_fifo.sv
// Instruction queue between the host command decoder and the GPU draw engine.
// A staging register collects one instruction and a push commits it to a show-ahead FIFO.
module gpu_instruction_fifo #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic [2:0]              quad_i,
  input  logic                    write_enable_i,
  input  logic                    push_instruction_i,
  input  logic                    pop_instruction_i,
  output logic                    fifo_empty_o,
  output logic                    fifo_full_o,
  output logic [3:0]              opcode_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [2:0]              quad_o
);

  localparam int unsigned EntryBits = 4 + 3 * WIDTH_BITS + 2 * HEIGHT_BITS
                                      + 3 * CHANNEL_BITS + 3;
  localparam int unsigned PtrBits   = $clog2(DEPTH);
  localparam int unsigned CntBits   = PtrBits + 1;

  typedef logic [EntryBits-1:0] entry_t;

  entry_t               stage_q, stage_d;
  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PtrBits-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrBits-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntBits-1:0]   count_q, count_d;
  logic                 push_en, pop_en;
  entry_t               head;

  assign fifo_empty_o = (count_q == '0);
  assign fifo_full_o  = (count_q == CntBits'(DEPTH));

  // A pop at full frees the slot the simultaneous push needs.
  assign pop_en  = pop_instruction_i && !fifo_empty_o;
  assign push_en = push_instruction_i && (!fifo_full_o || pop_en);

  always_comb begin
    stage_d  = stage_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (write_enable_i) begin
      stage_d = {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i, quad_i};
    end

    if (push_en) begin
      mem_d[wr_ptr_q] = stage_q;
      wr_ptr_d        = wr_ptr_q + PtrBits'(1);
    end

    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PtrBits'(1);
    end

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntBits'(1);
      2'b01:   count_d = count_q - CntBits'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      stage_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      stage_q  <= stage_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Show-ahead head; forced to zero when nothing valid is queued.
  assign head = fifo_empty_o ? '0 : mem_q[rd_ptr_q];

  assign {opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, quad_o} = head;

endmodule

// File: tb/tb_gpu_instruction_fifo.sv
// Directed self-checking bench for gpu_instruction_fifo.
module tb_gpu_instruction_fifo;

  localparam int unsigned WB = 10;
  localparam int unsigned HB = 9;
  localparam int unsigned CB = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [3:0]    opcode_i;
  logic [WB-1:0] x1_i, x2_i, rad_i;
  logic [HB-1:0] y1_i, y2_i;
  logic [CB-1:0] r_i, g_i, b_i;
  logic [2:0]    quad_i;
  logic          write_enable_i, push_instruction_i, pop_instruction_i;
  logic          fifo_empty_o, fifo_full_o;
  logic [3:0]    opcode_o;
  logic [WB-1:0] x1_o, x2_o, rad_o;
  logic [HB-1:0] y1_o, y2_o;
  logic [CB-1:0] r_o, g_o, b_o;
  logic [2:0]    quad_o;

  int n_checks = 0;
  int n_fails  = 0;

  gpu_instruction_fifo #(
    .WIDTH_BITS  (WB),
    .HEIGHT_BITS (HB),
    .CHANNEL_BITS(CB),
    .DEPTH       (8)
  ) u_dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .opcode_i          (opcode_i),
    .x1_i              (x1_i),
    .y1_i              (y1_i),
    .x2_i              (x2_i),
    .y2_i              (y2_i),
    .rad_i             (rad_i),
    .r_i               (r_i),
    .g_i               (g_i),
    .b_i               (b_i),
    .quad_i            (quad_i),
    .write_enable_i    (write_enable_i),
    .push_instruction_i(push_instruction_i),
    .pop_instruction_i (pop_instruction_i),
    .fifo_empty_o      (fifo_empty_o),
    .fifo_full_o       (fifo_full_o),
    .opcode_o          (opcode_o),
    .x1_o              (x1_o),
    .y1_o              (y1_o),
    .x2_o              (x2_o),
    .y2_o              (y2_o),
    .rad_o             (rad_o),
    .r_o               (r_o),
    .g_o               (g_o),
    .b_o               (b_o),
    .quad_o            (quad_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [WB-1:0] x1, input logic [HB-1:0] y1,
                            input logic [WB-1:0] x2, input logic [HB-1:0] y2,
                            input logic [WB-1:0] rad, input logic [CB-1:0] c,
                            input logic [2:0] q);
    opcode_i = op; x1_i = x1; y1_i = y1; x2_i = x2; y2_i = y2; rad_i = rad;
    r_i = c; g_i = c; b_i = c; quad_i = q;
  endtask

  task automatic stage(input logic [3:0] op, input logic [2:0] q);
    set_fields(op, WB'(op), HB'(q), WB'(3), HB'(4), WB'(2), CB'(7), q);
    write_enable_i = 1'b1;
    tick();
    write_enable_i = 1'b0;
  endtask

  task automatic push();
    push_instruction_i = 1'b1;
    tick();
    push_instruction_i = 1'b0;
  endtask

  task automatic pop();
    pop_instruction_i = 1'b1;
    tick();
    pop_instruction_i = 1'b0;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, quad_o});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_q [8];
    logic [3:0] exp_op [8];

    n_rst = 1'b1;
    write_enable_i = 1'b0; push_instruction_i = 1'b0; pop_instruction_i = 1'b0;
    set_fields(4'd0, '0, '0, '0, '0, '0, '0, 3'd0);
    tick();
    n_rst = 1'b0;

    // 1. reset state and pop while empty
    check("rst_empty", 128'(fifo_empty_o), 128'd1);
    check("rst_full", 128'(fifo_full_o), 128'd0);
    check("rst_outs", all_outs(), 128'd0);
    pop();
    check("pop_empty_empty", 128'(fifo_empty_o), 128'd1);
    check("pop_empty_outs", all_outs(), 128'd0);

    // 2. stage then push the first instruction
    set_fields(4'd4, WB'(0), HB'(0), WB'(10), HB'(10), WB'(5), CB'(32), 3'd1);
    write_enable_i = 1'b1;
    tick();
    write_enable_i = 1'b0;
    check("stage_only_empty", 128'(fifo_empty_o), 128'd1);
    push();
    check("push1_empty", 128'(fifo_empty_o), 128'd0);
    check("push1_op", 128'(opcode_o), 128'd4);
    check("push1_x2", 128'(x2_o), 128'd10);
    check("push1_y2", 128'(y2_o), 128'd10);
    check("push1_rad", 128'(rad_o), 128'd5);
    check("push1_rgb", 128'({r_o, g_o, b_o}), 128'h202020);
    check("push1_quad", 128'(quad_o), 128'd1);

    // 3. four more pushes, one pop, then four pushes using stage+push overlap
    for (int q = 0; q < 4; q++) begin
      stage(4'(8 + q), 3'(q));
      push();
    end
    pop();
    check("after_pop_op", 128'(opcode_o), 128'd8);
    stage(4'd12, 3'd0);
    for (int q = 1; q < 4; q++) begin
      set_fields(4'(12 + q), WB'(12 + q), HB'(q), WB'(3), HB'(4), WB'(2), CB'(7), 3'(q));
      write_enable_i = 1'b1;
      push_instruction_i = 1'b1;
      tick();
      write_enable_i = 1'b0;
      push_instruction_i = 1'b0;
    end
    push();
    check("fill_full", 128'(fifo_full_o), 128'd1);
    check("fill_empty", 128'(fifo_empty_o), 128'd0);
    stage(4'd3, 3'd7);
    push();
    check("ovf_full", 128'(fifo_full_o), 128'd1);
    check("ovf_head_op", 128'(opcode_o), 128'd8);
    check("ovf_head_quad", 128'(quad_o), 128'd0);

    // 4. drain in push order across the pointer wrap
    exp_q  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    exp_op = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_quad", i), 128'(quad_o), 128'(exp_q[i]));
      check($sformatf("drain%0d_op", i), 128'(opcode_o), 128'(exp_op[i]));
      pop();
      if (i == 0) check("drain_notfull", 128'(fifo_full_o), 128'd0);
    end
    check("drain_empty", 128'(fifo_empty_o), 128'd1);
    check("drain_outs", all_outs(), 128'd0);

    // 5a. push+pop at count 3
    for (int k = 1; k <= 3; k++) begin
      stage(4'(k), 3'(3 + k));
      push();
    end
    stage(4'd7, 3'd7);
    push_instruction_i = 1'b1;
    pop_instruction_i = 1'b1;
    tick();
    push_instruction_i = 1'b0;
    pop_instruction_i = 1'b0;
    check("pp3_head_op", 128'(opcode_o), 128'd2);
    pop();
    pop();
    check("pp3_two_pops_empty", 128'(fifo_empty_o), 128'd0);
    check("pp3_head_last", 128'(opcode_o), 128'd7);
    pop();
    check("pp3_three_pops_empty", 128'(fifo_empty_o), 128'd1);

    // 5b. push+pop while full
    for (int k = 0; k < 8; k++) begin
      stage(4'(k), 3'(k));
      push();
    end
    check("ppf_full_before", 128'(fifo_full_o), 128'd1);
    stage(4'd9, 3'd5);
    push_instruction_i = 1'b1;
    pop_instruction_i = 1'b1;
    tick();
    push_instruction_i = 1'b0;
    pop_instruction_i = 1'b0;
    check("ppf_full_after", 128'(fifo_full_o), 128'd1);
    check("ppf_head_op", 128'(opcode_o), 128'd1);
    for (int k = 0; k < 7; k++) pop();
    check("ppf_tail_op", 128'(opcode_o), 128'd9);
    check("ppf_tail_quad", 128'(quad_o), 128'd5);
    pop();
    check("ppf_final_empty", 128'(fifo_empty_o), 128'd1);

    // 6. reset mid-stream at count 5, with a push also requested
    for (int k = 0; k < 5; k++) begin
      stage(4'(k + 1), 3'(k));
      push();
    end
    stage(4'd6, 3'd6);
    n_rst = 1'b1;
    push_instruction_i = 1'b1;
    tick();
    n_rst = 1'b0;
    push_instruction_i = 1'b0;
    check("midrst_empty", 128'(fifo_empty_o), 128'd1);
    check("midrst_full", 128'(fifo_full_o), 128'd0);
    check("midrst_outs", all_outs(), 128'd0);
    push();
    check("midrst_stage_push_empty", 128'(fifo_empty_o), 128'd0);
    check("midrst_stage_cleared", all_outs(), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
